// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush/enable controls out.
interface mips_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             IDEXMemRead;
    logic [4:0]       IDEXRt;
    logic [4:0]       IFIDRs;
    logic [4:0]       IFIDRt;
    logic             IFIDUsesRt;
    logic             BranchTakenEX;
    logic             MemReqMEM;
    logic             DMemReady;
    logic             StatClr;
    logic             Stall;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             PipeFreeze;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt,
               BranchTakenEX, MemReqMEM, DMemReady, StatClr,
        input  Stall, PCWrite, IFIDWrite, IFIDFlush, PipeFreeze,
               MemTimeout, StallCount
    );

    modport slave (
        input  IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt,
               BranchTakenEX, MemReqMEM, DMemReady, StatClr,
        output Stall, PCWrite, IFIDWrite, IFIDFlush, PipeFreeze,
               MemTimeout, StallCount
    );
endinterface

// File: rtl/mips_load_use_detect.sv
// Combinational load-use comparator between the load in EX and the operands in ID.
module mips_load_use_detect
    import mips_pkg::*;
(
    input  logic       IDEXMemRead,
    input  logic [4:0] IDEXRt,
    input  logic [4:0] IFIDRs,
    input  logic [4:0] IFIDRt,
    input  logic       IFIDUsesRt,
    output logic       lu
);

    // $zero never carries a real dependency, so a load into it never stalls.
    assign lu = IDEXMemRead && (IDEXRt != REG_ZERO) &&
                ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait freeze
// with timeout, and a saturating stall-cycle counter.
//
// state   | meaning
// RUN     | normal issue; load-use / branch handled combinationally
// MEMWAIT | data memory busy; whole pipeline frozen, wait counter running
// ERROR   | wait exceeded MAX_WAIT; frozen with MemTimeout until reset
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    mips_hazard_ctrl_if.slave hz
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    hazard_state_t     state, nextState;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;
    logic [CNT_W-1:0]  statCnt;
    logic              lu;
    logic              applyRun;
    logic              stall, pcWrite, ifidWrite, ifidFlush, pipeFreeze;

    mips_load_use_detect uLuDetect (
        .IDEXMemRead (hz.IDEXMemRead),
        .IDEXRt      (hz.IDEXRt),
        .IFIDRs      (hz.IFIDRs),
        .IFIDRt      (hz.IFIDRt),
        .IFIDUsesRt  (hz.IFIDUsesRt),
        .lu          (lu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        nextState   = state;
        waitCntNext = waitCnt;
        applyRun    = 1'b0;
        stall       = 1'b0;
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        pipeFreeze  = 1'b0;

        unique case (state)
            RUN: begin
                if (hz.MemReqMEM && !hz.DMemReady) begin
                    pipeFreeze  = 1'b1;
                    pcWrite     = 1'b0;
                    ifidWrite   = 1'b0;
                    nextState   = MEMWAIT;
                    waitCntNext = WAIT_W'(1);
                end else begin
                    applyRun = 1'b1;
                end
            end
            MEMWAIT: begin
                if (!hz.DMemReady) begin
                    pipeFreeze = 1'b1;
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    // Counter stops at the limit; the ERROR state takes over from there.
                    if (waitCnt == WAIT_LIMIT) begin
                        nextState = ERROR;
                    end else begin
                        waitCntNext = waitCnt + 1'b1;
                    end
                end else begin
                    applyRun    = 1'b1;
                    nextState   = RUN;
                    waitCntNext = '0;
                end
            end
            ERROR: begin
                pipeFreeze = 1'b1;
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
            end
            default: begin
                nextState   = RUN;
                waitCntNext = '0;
            end
        endcase

        // Release cycle of a wait uses the same rules as RUN, so a held branch fires here.
        if (applyRun) begin
            if (hz.BranchTakenEX) begin
                ifidFlush = 1'b1;
                stall     = 1'b1;
                pcWrite   = 1'b1;
            end else if (lu) begin
                stall     = 1'b1;
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
            end
        end

        if (rst) begin
            stall      = 1'b1;
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b0;
            pipeFreeze = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statCnt <= '0;
        end else if (hz.StatClr) begin
            statCnt <= '0;
        end else if ((stall || pipeFreeze || ifidFlush) && (statCnt != '1)) begin
            statCnt <= statCnt + 1'b1;
        end
    end

    assign hz.Stall      = stall;
    assign hz.PCWrite    = pcWrite;
    assign hz.IFIDWrite  = ifidWrite;
    assign hz.IFIDFlush  = ifidFlush;
    assign hz.PipeFreeze = pipeFreeze;
    assign hz.MemTimeout = (state == ERROR);
    assign hz.StallCount = statCnt;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl (MAX_WAIT=4, CNT_W=4) with an expected-value queue.
module tb_mips_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    // Control vector order: {Stall, PCWrite, IFIDWrite, IFIDFlush, PipeFreeze, MemTimeout}
    localparam logic [5:0] NORM  = 6'b011000;
    localparam logic [5:0] LU    = 6'b100000;
    localparam logic [5:0] BR    = 6'b110100;
    localparam logic [5:0] FRZ   = 6'b000010;
    localparam logic [5:0] ERR   = 6'b000011;
    localparam logic [5:0] RSTV  = 6'b100000;
    localparam logic [5:0] ALL   = 6'b111111;
    localparam logic [5:0] NOIFW = 6'b110111;

    typedef struct {
        string            tag;
        logic [5:0]       ctl;
        logic [5:0]       mask;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic [CNT_W-1:0] expCnt = '0;
    exp_t sb[$];

    mips_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

    mips_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic setIn(input logic mr, input logic [4:0] exRt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic usesRt, input logic br,
                         input logic mreq, input logic rdy, input logic clr);
        hz.IDEXMemRead   = mr;
        hz.IDEXRt        = exRt;
        hz.IFIDRs        = rs;
        hz.IFIDRt        = rt;
        hz.IFIDUsesRt    = usesRt;
        hz.BranchTakenEX = br;
        hz.MemReqMEM     = mreq;
        hz.DMemReady     = rdy;
        hz.StatClr       = clr;
    endtask

    task automatic pushExp(input string tag, input logic [5:0] ctl, input logic [5:0] mask);
        exp_t e;
        e.tag  = tag;
        e.ctl  = ctl;
        e.mask = mask;
        e.cnt  = expCnt;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [5:0] obs;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL scoreboard_empty observed=0 expected=1 entries");
            return;
        end
        e   = sb.pop_front();
        obs = {hz.Stall, hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.PipeFreeze, hz.MemTimeout};
        checks++;
        assert ((obs & e.mask) === (e.ctl & e.mask)) passed++;
        else $error("FAIL %s ctl observed=%b expected=%b mask=%b", e.tag, obs, e.ctl, e.mask);
        checks++;
        assert (hz.StallCount === e.cnt) passed++;
        else $error("FAIL %s StallCount observed=%0d expected=%0d", e.tag, hz.StallCount, e.cnt);
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, advance the count model.
    task automatic step(input string tag, input logic mr, input logic [4:0] exRt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                        input logic br, input logic mreq, input logic rdy, input logic clr,
                        input logic [5:0] ctl, input logic [5:0] mask);
        setIn(mr, exRt, rs, rt, usesRt, br, mreq, rdy, clr);
        pushExp(tag, ctl, mask);
        @(negedge clk);
        compare();
        if (clr) expCnt = '0;
        else if ((ctl[5] || ctl[2] || ctl[1]) && (expCnt != '1)) expCnt = expCnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [5:0] ctl, input logic [5:0] mask);
        step(tag, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ctl, mask);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        setIn(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        #3;
        pushExp("reset", RSTV, ALL);
        compare();
        @(posedge clk); #1;
        rst = 1'b0;
        expCnt = '0;

        idle("idle", NORM, ALL);
        step("lu_rs", 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1, 0, LU, ALL);
        idle("lu_release", NORM, ALL);
        step("rt_zero", 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, NORM, ALL);
        step("rt_unused", 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 1, 0, NORM, ALL);
        step("lu_rt", 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 1, 0, LU, ALL);
        step("clr_idle", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, NORM, ALL);

        for (int i = 0; i < 3; i++)
            step("memwait", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FRZ, ALL);
        step("mem_release", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, NORM, ALL);
        idle("after_mem", NORM, ALL);

        step("br_lu", 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1, 0, BR, NOIFW);
        step("wait_req", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FRZ, ALL);
        step("wait_br", 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, 0, FRZ, ALL);
        step("release_br", 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 1, 0, BR, NOIFW);
        step("clr_after_br", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, NORM, ALL);

        for (int i = 0; i < MAX_WAIT + 1; i++)
            step("to_wait", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FRZ, ALL);
        step("to_error", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, ERR, ALL);
        for (int i = 0; i < 16; i++)
            step("err_sat", 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1, 0, ERR, ALL);
        step("clr_in_err", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, ERR, ALL);
        step("err_after_clr", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ERR, ALL);

        rst = 1'b1;
        #1;
        expCnt = '0;
        pushExp("async_rst_err", RSTV, ALL);
        compare();
        @(posedge clk); #1;
        rst = 1'b0;

        step("mid_wait_a", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FRZ, ALL);
        step("mid_wait_b", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FRZ, ALL);
        setIn(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        expCnt = '0;
        pushExp("async_rst_wait", RSTV, ALL);
        compare();
        @(posedge clk); #1;
        rst = 1'b0;
        step("run_after_rst", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM, ALL);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
